// File: rtl/timer_pkg.sv
// Shared definitions for the timer controller: state encoding and default widths.
package timer_pkg;

    localparam int unsigned W_DEF  = 16;
    localparam int unsigned PW_DEF = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/timer_ctrl_if.sv
// CSR-side bundle of the timer controller: configuration, control strobes and status.
interface timer_ctrl_if
    import timer_pkg::*;
#(
    parameter int unsigned W  = W_DEF,
    parameter int unsigned PW = PW_DEF
);

    logic [W-1:0]  cfg_period;
    logic [PW-1:0] cfg_prescale;
    logic          cfg_periodic;
    logic          start;
    logic          stop;
    logic          irq_ack;
    logic          busy;
    logic [W-1:0]  count;
    logic          expire;
    logic          irq;
    logic          overrun;

    modport master (
        output cfg_period, cfg_prescale, cfg_periodic, start, stop, irq_ack,
        input  busy, count, expire, irq, overrun
    );

    modport slave (
        input  cfg_period, cfg_prescale, cfg_periodic, start, stop, irq_ack,
        output busy, count, expire, irq, overrun
    );

endinterface

// File: rtl/timer_ctrl_countdown.sv
// Loadable saturating down-counter: load on put, otherwise decrement and hold at zero.
module timer_ctrl_countdown #(
    parameter int unsigned W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         put,
    input  logic [W-1:0] value,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (put) begin
            count_d = value;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/timer_ctrl.sv
// Timer controller: prescaled down-counter with one-shot/periodic modes, expiry strobe,
// sticky irq and overrun. Configuration is shadowed at start.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned W  = W_DEF,
    parameter int unsigned PW = PW_DEF
) (
    input  logic         clock,
    input  logic         reset,
    timer_ctrl_if.slave  bus
);

    state_e        state_q, state_d;
    logic [W-1:0]  count_q, count_d;
    logic [W-1:0]  sh_period_q, sh_period_d;
    logic [PW-1:0] sh_prescale_q, sh_prescale_d;
    logic          sh_periodic_q, sh_periodic_d;
    logic          busy_q, busy_d;
    logic          expire_q, expire_d;
    logic          irq_q, irq_d;
    logic          overrun_q, overrun_d;

    logic [PW-1:0] presc;
    logic [PW-1:0] presc_value_c;
    logic          presc_put_c;
    logic          tick_c;
    logic          expiry_c;

    // Prescaler: reloaded at start and on every tick, idles down to zero otherwise.
    assign presc_value_c = bus.start ? bus.cfg_prescale : sh_prescale_q;
    assign presc_put_c   = bus.start || tick_c;

    timer_ctrl_countdown #(.W(PW)) u_presc (
        .clock (clock),
        .reset (reset),
        .put   (presc_put_c),
        .value (presc_value_c),
        .count (presc)
    );

    assign tick_c   = (state_q == ST_RUN) && (presc == '0);
    // stop and (re)start both suppress an expiry that would land on the same edge.
    assign expiry_c = tick_c && !bus.stop && !bus.start && (count_q == '0);

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        sh_period_d   = sh_period_q;
        sh_prescale_d = sh_prescale_q;
        sh_periodic_d = sh_periodic_q;
        expire_d      = 1'b0;

        if (bus.start) begin
            sh_period_d   = bus.cfg_period;
            sh_prescale_d = bus.cfg_prescale;
            sh_periodic_d = bus.cfg_periodic;
        end

        if (bus.stop) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else if (bus.start) begin
            state_d = ST_RUN;
            count_d = bus.cfg_period;
        end else if (tick_c) begin
            if (count_q != '0) begin
                count_d = count_q - W'(1);
            end else begin
                expire_d = 1'b1;
                if (sh_periodic_q) begin
                    count_d = sh_period_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        end

        busy_d = (state_d == ST_RUN);

        // Set wins over acknowledge for both sticky flags.
        irq_d = irq_q;
        if (expiry_c) begin
            irq_d = 1'b1;
        end else if (bus.irq_ack) begin
            irq_d = 1'b0;
        end

        overrun_d = overrun_q;
        if (expiry_c && irq_q && !bus.irq_ack) begin
            overrun_d = 1'b1;
        end else if (bus.irq_ack && !expiry_c) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            count_q       <= '0;
            sh_period_q   <= '0;
            sh_prescale_q <= '0;
            sh_periodic_q <= 1'b0;
            busy_q        <= 1'b0;
            expire_q      <= 1'b0;
            irq_q         <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            sh_period_q   <= sh_period_d;
            sh_prescale_q <= sh_prescale_d;
            sh_periodic_q <= sh_periodic_d;
            busy_q        <= busy_d;
            expire_q      <= expire_d;
            irq_q         <= irq_d;
            overrun_q     <= overrun_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.count   = count_q;
    assign bus.expire  = expire_q;
    assign bus.irq     = irq_q;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard bench for timer_ctrl: driver steps a timeline-based reference model and
// queues expected outputs; a monitor pops and compares after each clock edge.
module tb_timer_ctrl;

    localparam int unsigned W  = 16;
    localparam int unsigned PW = 8;

    typedef struct {
        int busy;
        int count;
        int expire;
        int irq;
        int overrun;
    } exp_t;

    logic clock;
    logic reset;

    timer_ctrl_if #(.W(W), .PW(PW)) ifc ();

    timer_ctrl #(.W(W), .PW(PW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_seen = 0;
    int   mon_cyc  = 0;
    exp_t sb_q[$];

    // Reference model: time elapsed since start within the current period.
    bit m_run, m_per, m_irq, m_ovr;
    int m_e, m_p, m_s;
    int cur_p, cur_s;
    bit cur_per;

    task automatic chk(input string name, input longint got, input longint want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic step(input bit rst, input bit st, input bit sp, input bit ack,
                        input int p, input int s, input bit per);
        exp_t e;
        bit   fire;
        bit   n_irq, n_ovr;
        @(negedge clock);
        reset            = rst;
        ifc.start        = st;
        ifc.stop         = sp;
        ifc.irq_ack      = ack;
        ifc.cfg_period   = W'(p);
        ifc.cfg_prescale = PW'(s);
        ifc.cfg_periodic = per;
        cur_p = p; cur_s = s; cur_per = per;
        fire = 1'b0;
        if (rst) begin
            m_run = 0; m_per = 0; m_irq = 0; m_ovr = 0;
            m_e = 0; m_p = 0; m_s = 0;
        end else begin
            if (sp) begin
                m_run = 0;
            end else if (st) begin
                m_run = 1; m_e = 0; m_p = p; m_s = s; m_per = per;
            end else if (m_run) begin
                m_e++;
                if (m_e == (m_p + 1) * (m_s + 1)) begin
                    fire = 1'b1;
                    m_e  = 0;
                    if (!m_per) m_run = 0;
                end
            end
            n_irq = fire ? 1'b1 : (ack ? 1'b0 : m_irq);
            n_ovr = (fire && m_irq && !ack) ? 1'b1 : ((ack && !fire) ? 1'b0 : m_ovr);
            m_irq = n_irq;
            m_ovr = n_ovr;
        end
        e.busy    = m_run;
        e.count   = m_run ? (m_p - m_e / (m_s + 1)) : 0;
        e.expire  = fire;
        e.irq     = m_irq;
        e.overrun = m_ovr;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, cur_p, cur_s, cur_per);
    endtask

    task automatic settle();
        @(posedge clock);
        #2;
    endtask

    // Monitor: one expected record per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                mon_cyc++;
                if (ifc.expire === 1'b1) exp_seen++;
                chk($sformatf("cyc%0d busy", mon_cyc),    longint'(ifc.busy),    e.busy);
                chk($sformatf("cyc%0d count", mon_cyc),   longint'(ifc.count),   e.count);
                chk($sformatf("cyc%0d expire", mon_cyc),  longint'(ifc.expire),  e.expire);
                chk($sformatf("cyc%0d irq", mon_cyc),     longint'(ifc.irq),     e.irq);
                chk($sformatf("cyc%0d overrun", mon_cyc), longint'(ifc.overrun), e.overrun);
            end
        end
    end

    initial begin
        int base;
        reset = 1'b1;
        ifc.start = 1'b0; ifc.stop = 1'b0; ifc.irq_ack = 1'b0;
        ifc.cfg_period = '0; ifc.cfg_prescale = '0; ifc.cfg_periodic = 1'b0;
        cur_p = 0; cur_s = 0; cur_per = 0;

        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);

        // One-shot P=3 S=0: single expire, then idle with irq pending.
        settle(); base = exp_seen;
        step(0, 1, 0, 0, 3, 0, 0);
        idle(10);
        settle(); chk("oneshot_expires", exp_seen - base, 1);

        // Periodic P=2 S=1: expires at 6, 12, 18.
        step(0, 0, 0, 1, 0, 0, 0);
        settle(); base = exp_seen;
        step(0, 1, 0, 0, 2, 1, 1);
        idle(18);
        settle(); chk("periodic_expires", exp_seen - base, 3);
        step(0, 0, 1, 1, 2, 1, 1);

        // Stop mid-run, then start+stop together.
        settle(); base = exp_seen;
        step(0, 1, 0, 0, 5, 0, 0);
        idle(2);
        step(0, 0, 1, 0, 5, 0, 0);
        idle(20);
        step(0, 1, 1, 0, 5, 0, 1);
        idle(5);
        settle(); chk("stop_no_expire", exp_seen - base, 0);

        // Restart at cycle 3; cfg change in cycle 5 is ignored.
        settle(); base = exp_seen;
        step(0, 1, 0, 0, 4, 0, 0);
        idle(2);
        step(0, 1, 0, 0, 4, 0, 0);
        idle(1);
        step(0, 0, 0, 0, 9, 3, 1);
        idle(2);
        settle(); chk("restart_before8", exp_seen - base, 0);
        idle(1);
        settle(); chk("restart_at8", exp_seen - base, 1);
        idle(3);

        // IRQ/overrun with P=0 S=0 periodic.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 1);
        idle(3);
        step(0, 0, 0, 1, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0, 1);
        idle(1);
        step(0, 0, 0, 1, 0, 0, 1);
        idle(2);

        // Reset mid-run of P=7.
        settle(); base = exp_seen;
        step(0, 1, 0, 0, 7, 0, 0);
        idle(1);
        step(1, 0, 0, 0, 7, 0, 0);
        idle(12);
        settle(); chk("reset_abort", exp_seen - base, 0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(199) == 0),
                 ($urandom_range(11) == 0),
                 ($urandom_range(39) == 0),
                 ($urandom_range(5) == 0),
                 int'($urandom_range(6)),
                 int'($urandom_range(3)),
                 bit'($urandom_range(1)));
        end

        settle();
        settle();
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
Programmable timer controller: sequences a prescaler and a main down-counter, and provides one-shot and periodic modes, start/stop control, an expiry strobe and a sticky interrupt with overrun detection. It sits between a register/CSR front end and the timer datapath. Configuration is shadowed at start, so CSR writes never disturb a running period.

Parameters:
W, 16, main counter / period width
PW, 8, prescaler width

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high
cfg_period  input  W  period value P
cfg_prescale  input  PW  prescale value S; tick every S+1 cycles
cfg_periodic  input  1  1 = auto-reload, 0 = one-shot
start  input  1  one-cycle strobe: latch config, (re)arm
stop  input  1  one-cycle strobe: halt
irq_ack  input  1  clears irq and overrun
busy  output  1  high in RUN
count  output  W  current main counter value
expire  output  1  one-cycle registered strobe per expiry
irq  output  1  sticky pending flag
overrun  output  1  sticky: expiry while irq still pending

Behaviour:
- Reset state: IDLE. count=0, prescaler=0, shadows=0, busy=0, expire=0, irq=0, overrun=0. A reset mid-run aborts at once, and the same reset values apply.
- States: IDLE, RUN. busy is registered (state==RUN).
- Shadows: on start, latch sh_period<=cfg_period, sh_prescale<=cfg_prescale, sh_periodic<=cfg_periodic. cfg_* are ignored at all other times.
- Start, from any state, at the same edge: count<=cfg_period, prescaler<=cfg_prescale, state<=RUN. A start in RUN is a full restart: the partial period is discarded and no expire occurs.
- stop: state<=IDLE, count<=0, and no expire. If stop and start are asserted in the same cycle, stop wins.
- tick = RUN && prescaler==0 (combinational).
- Prescaler in RUN: if tick, reload sh_prescale; otherwise decrement. In IDLE it decrements to 0 and holds; it has no effect there.
- Main counter, on tick:
  - if count!=0, count-1;
  - if count==0, expiry: expire<=1 for the next cycle.
    - Periodic: count<=sh_period and stay in RUN.
    - One-shot: state<=IDLE, count stays 0.
- Latency: the first expire is asserted (P+1)*(S+1) edges after the start edge. A periodic timer repeats every (P+1)*(S+1) cycles. P=0, S=0 periodic gives expire every cycle.
- Width rules: all arithmetic is unsigned. Widths are exactly W and PW. There is no wrap below 0.
- irq: set on expiry and cleared by irq_ack. If expiry and irq_ack occur in the same cycle, irq stays 1 (set wins).
- overrun: set when an expiry occurs while irq==1 and irq_ack==0. It is cleared by irq_ack unless that same cycle's expiry sets it again, so set wins here too.
- stop and start do not touch irq or overrun.

Decomposition:
- Shared package timer_pkg holds the state encoding localparams (ST_IDLE, ST_RUN) and a default W/PW.
- Natural sub-module: the team's existing countdown block as the prescaler, with W=PW, value=start ? cfg_prescale : sh_prescale, and put=start || tick. It has reset-to-0, load-on-put and saturating decrement semantics.
- The main counter stays in timer_ctrl, because it needs tick-gated decrement.

Test Plan:
- One-shot, P=3, S=0, start at cycle 0: expire high at cycle 4 only; busy falls at the same edge; count=0; irq=1 thereafter.
- Periodic, P=2, S=1: expire at cycles 6, 12 and 18; count sequence 2,2,1,1,0,0,2...; busy stays 1.
- Stop at cycle 3 of P=5, S=0: busy=0 and count=0 next cycle; no expire within 20 cycles. Then start and stop in the same cycle: the block stays IDLE.
- Restart: start at cycle 0 with P=4, S=0 and again at cycle 3. The first expire appears at cycle 8. A cfg_period change in cycle 5 does not alter the period.
- IRQ/overrun, periodic P=0, S=0 with no ack: irq=1 after the first expire and overrun=1 after the second. irq_ack in a cycle with a coincident expire leaves irq=1 and overrun=1; irq_ack in a non-expire cycle clears both.
- Reset at cycle 2 of a P=7 run: all outputs are 0 the next cycle, and no expire follows.
